alu_instr_seq: RTL and testbench

- Upstream instruction sequencer for the 4-bit accumulator ALU.
- Holds a small program of {Inst, A} words written by a host.
- On start, it clears the ALU accumulator, then issues one word per cycle and waits one drain cycle.
- It then captures the ALU accumulator output as the result and pulses done; between runs it drives a NOP so the accumulator holds.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_prog_mem.sv | 43 ++++
 rtl/alu_instr_seq.sv | 116 +++++++++++
 tb/tb_alu_instr_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, NOP word and sequencer state encoding
package alu_pkg;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_SHIFT = 2'b10;
  localparam logic [1:0] OP_XNOR  = 2'b11;

  // ADD 0 leaves the accumulator unchanged
  localparam logic [5:0] NOP_WORD = 6'b000000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/alu_prog_mem.sv
// rtl/alu_prog_mem.sv - DEPTH x 6 program register file, sync write, async read
module alu_prog_mem
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [5:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [5:0]    rdata
);

  logic [5:0] mem_q [DEPTH];
  logic [5:0] mem_d [DEPTH];

  // Next contents: one word replaced on a write, everything else held
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage; reset fills the program with NOPs
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        mem_q[i] <= NOP_WORD;
      end else begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_instr_seq.sv
// rtl/alu_instr_seq.sv - sequencer issuing a stored program to the accumulator ALU
module alu_instr_seq
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [5:0]    wr_data,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic [3:0]    alu_out,
  output logic [1:0]    alu_Inst,
  output logic [3:0]    alu_A,
  output logic          alu_rst,
  output logic          busy,
  output logic          done,
  output logic [3:0]    result
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  seq_state_t  state_q, state_d;
  logic [AW:0] pc_q, pc_d;
  logic [AW:0] eff_len_q, eff_len_d;
  logic [3:0]  result_q, result_d;
  logic [5:0]  mem_rdata;
  logic [5:0]  word;
  logic        mem_we;

  // Program writes only land while the sequencer is idle
  assign mem_we = wr_en && (state_q == ST_IDLE);

  alu_prog_mem #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_prog_mem (
    .clk  (clk),
    .rst  (RESET),
    .we   (mem_we),
    .waddr(wr_addr),
    .wdata(wr_data),
    .raddr(pc_q[AW-1:0]),
    .rdata(mem_rdata)
  );

  // Next-state, pc/length/result updates and ALU-facing outputs
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    eff_len_d = eff_len_q;
    result_d  = result_q;
    word      = NOP_WORD;
    alu_rst   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_CLEAR;
          eff_len_d = (len > DEPTH_W) ? DEPTH_W : len;
          pc_d      = '0;
        end
      end
      ST_CLEAR: begin
        alu_rst = 1'b1;
        busy    = 1'b1;
        state_d = (eff_len_q != '0) ? ST_RUN : ST_DRAIN;
      end
      ST_RUN: begin
        busy = 1'b1;
        word = mem_rdata;
        pc_d = pc_q + (AW + 1)'(1);
        if (pc_q == eff_len_q - (AW + 1)'(1)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The last word has been executed by now; take the accumulator
        busy     = 1'b1;
        result_d = alu_out;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pc, run length and result registers
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      eff_len_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      eff_len_q <= eff_len_d;
      result_q  <= result_d;
    end
  end

  assign alu_Inst = word[5:4];
  assign alu_A    = word[3:0];
  assign result   = result_q;

endmodule

// File: tb/tb_alu_instr_seq.sv
// tb/tb_alu_instr_seq.sv - directed vector bench for alu_instr_seq with an accumulator ALU
module tb_alu_instr_seq;
  import alu_pkg::*;

  logic       clk;
  logic       RESET;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [5:0] wr_data;
  logic       start;
  logic [3:0] len;
  logic [3:0] alu_out;
  logic [1:0] alu_Inst;
  logic [3:0] alu_A;
  logic       alu_rst;
  logic       busy;
  logic       done;
  logic [3:0] result;

  int errors = 0;
  int checks = 0;

  int rst_cnt, rst_first, busy_cnt, done_cnt, done_at, issued;

  alu_instr_seq #(.DEPTH(8), .AW(3)) dut (
    .clk     (clk),
    .RESET   (RESET),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .len     (len),
    .alu_out (alu_out),
    .alu_Inst(alu_Inst),
    .alu_A   (alu_A),
    .alu_rst (alu_rst),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accumulator ALU the sequencer drives; shift amount is 1 + index of the one-hot bit
  logic [3:0] acc;
  function automatic logic [3:0] alu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] o);
    int sh;
    case (a[2:0])
      3'b001:  sh = 1;
      3'b010:  sh = 2;
      3'b100:  sh = 3;
      default: sh = 0;
    endcase
    case (op)
      OP_ADD:   return o + a;
      OP_SUB:   return o - a;
      OP_SHIFT: return a[3] ? (o >> sh) : (o << sh);
      default:  return ~(a ^ o);
    endcase
  endfunction

  always @(posedge clk) begin
    if (RESET || alu_rst) acc <= 4'd0;
    else                  acc <= alu_f(alu_Inst, alu_A, acc);
  end
  assign alu_out = acc;

  typedef struct {
    logic [5:0] prog [8];
    logic [3:0] len;
    int         exp_result;
    int         exp_done;
    int         exp_busy;
    int         exp_issued;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_prog(input logic [5:0] p [8]);
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = p[i];
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Start a run and observe 40 cycles; optional mid-run start/write at inj, RESET at rstn
  task automatic run(input logic [3:0] l, input int inj, input int rstn);
    len = l; start = 1'b1;
    tick();
    start = 1'b0;
    rst_cnt = 0; rst_first = -1; busy_cnt = 0; done_cnt = 0; done_at = -1; issued = 0;
    for (int n = 0; n < 40; n++) begin
      if (alu_rst) begin rst_cnt++; if (rst_first < 0) rst_first = n; end
      if (busy) busy_cnt++;
      if ({alu_Inst, alu_A} != NOP_WORD) issued++;
      if (done) begin done_cnt++; if (done_at < 0) done_at = n; end
      if (n == inj) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = {OP_ADD, 4'hF};
      end
      if (n == rstn) RESET = 1'b1;
      tick();
      start = 1'b0; wr_en = 1'b0; RESET = 1'b0;
      if (n == rstn) break;
    end
  endtask

  task automatic chk_run(input string tag, input int exp_res, input int exp_done,
                         input int exp_busy, input int exp_issued);
    chk({tag, " result"}, int'(result), exp_res);
    chk({tag, " done_at"}, done_at, exp_done);
    chk({tag, " done_cnt"}, done_cnt, 1);
    chk({tag, " busy_cnt"}, busy_cnt, exp_busy);
    chk({tag, " alu_rst_cnt"}, rst_cnt, 1);
    chk({tag, " alu_rst_first"}, rst_first, 0);
    chk({tag, " issued"}, issued, exp_issued);
  endtask

  initial begin
    logic [5:0] p [8];
    vecs[0].prog = '{{OP_ADD,4'd5}, {OP_ADD,4'd3}, {OP_SUB,4'd2}, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    vecs[0].len = 4'd3;  vecs[0].exp_result = 6;  vecs[0].exp_done = 5;  vecs[0].exp_busy = 5;  vecs[0].exp_issued = 3;
    vecs[1].prog = '{{OP_ADD,4'd6}, {OP_XNOR,4'b0101}, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    vecs[1].len = 4'd2;  vecs[1].exp_result = 12; vecs[1].exp_done = 4;  vecs[1].exp_busy = 4;  vecs[1].exp_issued = 2;
    vecs[2].prog = '{{OP_ADD,4'd3}, {OP_SHIFT,4'b0001}, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    vecs[2].len = 4'd2;  vecs[2].exp_result = 6;  vecs[2].exp_done = 4;  vecs[2].exp_busy = 4;  vecs[2].exp_issued = 2;
    vecs[3].prog = '{{OP_ADD,4'd7}, {OP_ADD,4'd1}, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    vecs[3].len = 4'd0;  vecs[3].exp_result = 0;  vecs[3].exp_done = 2;  vecs[3].exp_busy = 2;  vecs[3].exp_issued = 0;
    for (int i = 0; i < 8; i++) vecs[4].prog[i] = {OP_ADD, 4'd1};
    vecs[4].len = 4'd15; vecs[4].exp_result = 8;  vecs[4].exp_done = 10; vecs[4].exp_busy = 10; vecs[4].exp_issued = 8;
    for (int i = 0; i < 8; i++) vecs[5].prog[i] = {OP_ADD, 4'd2};
    vecs[5].len = 4'd8;  vecs[5].exp_result = 0;  vecs[5].exp_done = 10; vecs[5].exp_busy = 10; vecs[5].exp_issued = 8;

    RESET = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; len = '0;
    tick(); tick();
    RESET = 1'b0;
    tick();

    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset result", int'(result), 0);
    chk("reset alu_rst", int'(alu_rst), 0);
    chk("reset word", int'({alu_Inst, alu_A}), 0);

    for (int v = 0; v < 6; v++) begin
      load_prog(vecs[v].prog);
      run(vecs[v].len, -1, -1);
      chk_run($sformatf("vec%0d", v), vecs[v].exp_result, vecs[v].exp_done,
              vecs[v].exp_busy, vecs[v].exp_issued);
    end

    // Start and program write arriving mid-run are both dropped
    p = '{{OP_ADD,4'd1}, {OP_ADD,4'd2}, {OP_ADD,4'd3}, {OP_ADD,4'd4}, 6'd0, 6'd0, 6'd0, 6'd0};
    load_prog(p);
    run(4'd4, 2, -1);
    chk_run("midrun", 10, 6, 6, 4);
    run(4'd1, -1, -1);
    chk_run("word0 kept", 1, 3, 3, 1);

    // RESET in the second RUN cycle abandons the run and clears the program
    p = '{{OP_ADD,4'd9}, {OP_ADD,4'd2}, {OP_ADD,4'd3}, {OP_ADD,4'd4}, 6'd0, 6'd0, 6'd0, 6'd0};
    load_prog(p);
    run(4'd4, -1, 2);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst result", int'(result), 0);
    chk("rst alu_rst", int'(alu_rst), 0);
    chk("rst word", int'({alu_Inst, alu_A}), 0);
    tick(); tick();
    chk("rst idle busy", int'(busy), 0);
    run(4'd1, -1, -1);
    chk_run("after rst", 0, 3, 3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
